// File: rtl/alu_cmd_issuer.sv
// Command front-end for alu_4bit. It turns two-byte commands into ALU operand and
// opcode registers and queues the ALU's registered results in a small FIFO.
module alu_cmd_issuer #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_op,
    input  logic [7:0] alu_result,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       sync_err
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    typedef enum logic [1:0] {S_HDR, S_OPND, S_EXEC, S_CAPT} state_t;

    state_t           state_q;
    logic [2:0]       hdr_op_q;
    logic [3:0]       alu_a_q;
    logic [3:0]       alu_b_q;
    logic [2:0]       alu_op_q;
    logic             sync_err_q;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [7:0]       mem_q [DEPTH];

    logic in_fire;
    logic push;
    logic pop;
    logic fifo_full;
    logic unused_hdr_bits;

    // Header bits [6:3] carry no meaning.
    assign unused_hdr_bits = ^in_data[6:3];

    assign in_ready  = rst_n && ((state_q == S_HDR) || (state_q == S_OPND));
    assign in_fire   = in_valid && in_ready;
    assign out_valid = rst_n && (count_q != '0);
    assign pop       = out_valid && out_ready;
    assign fifo_full = (count_q == FULL_CNT);
    // A full FIFO still accepts the push when the head leaves on the same edge.
    assign push      = rst_n && (state_q == S_CAPT) && (!fifo_full || pop);
    assign out_data  = mem_q[rd_ptr_q];

    assign alu_a    = alu_a_q;
    assign alu_b    = alu_b_q;
    assign alu_op   = alu_op_q;
    assign sync_err = sync_err_q;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_HDR;
            hdr_op_q   <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= '0;
            sync_err_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            case (state_q)
                S_HDR: begin
                    if (in_fire) begin
                        if (in_data[7]) begin
                            hdr_op_q <= in_data[2:0];
                            state_q  <= S_OPND;
                        end else begin
                            sync_err_q <= 1'b1;
                        end
                    end
                end
                S_OPND: begin
                    if (in_fire) begin
                        alu_a_q  <= in_data[7:4];
                        alu_b_q  <= in_data[3:0];
                        alu_op_q <= hdr_op_q;
                        state_q  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    state_q <= S_CAPT;
                end
                S_CAPT: begin
                    if (push) begin
                        state_q <= S_HDR;
                    end
                end
                default: state_q <= S_HDR;
            endcase
        end
    end

    // Result storage has no reset; contents are only visible while counted valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= alu_result;
        end
    end
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Bench for alu_cmd_issuer: a behavioural ALU stub drives alu_result, and a scoreboard
// queue filled at command issue is checked by an independent output monitor.
module tb_alu_cmd_issuer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_op;
    logic [7:0] alu_result = 8'h00;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       sync_err;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int n_pops = 0;
    logic [7:0] sb[$];
    int pop_cyc[$];

    logic rdy_mode = 1'b0;
    logic rdy_man = 1'b0;

    logic       hdr_pending = 1'b0;
    logic [2:0] hdr_op = 3'd0;
    logic       exp_sync = 1'b0;

    alu_cmd_issuer #(.DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .sync_err(sync_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [7:0] alu_ref(input logic [3:0] a, input logic [3:0] b,
                                           input logic [2:0] op);
        logic [7:0] xa, xb;
        xa = {4'h0, a};
        xb = {4'h0, b};
        case (op)
            3'd0: return xa + xb;
            3'd1: return xa - xb;
            3'd2: return xa & xb;
            3'd3: return xa | xb;
            3'd4: return xa ^ xb;
            3'd5: return xa >> b;
            3'd6: return xa << b;
            default: return (a > b) ? 8'd1 : 8'd0;
        endcase
    endfunction

    // ALU stand-in: result registered one edge after the operands.
    always @(posedge clk) alu_result <= alu_ref(alu_a, alu_b, alu_op);

    always @(posedge clk) begin
        #2;
        out_ready = rdy_mode ? 1'($urandom_range(0, 1)) : rdy_man;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out actual=%0h required=none", out_data);
            end else begin
                chk("out_data", 32'(out_data), 32'(sb.pop_front()));
                n_pops++;
                pop_cyc.push_back(cyc);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        in_data  = b;
        in_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            chk("in_ready_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (!hdr_pending) begin
            if (b[7]) begin
                hdr_pending = 1'b1;
                hdr_op = b[2:0];
            end else begin
                exp_sync = 1'b1;
            end
        end else begin
            hdr_pending = 1'b0;
            sb.push_back(alu_ref(b[7:4], b[3:0], hdr_op));
            chk("alu_a", 32'(alu_a), 32'(b[7:4]));
            chk("alu_b", 32'(alu_b), 32'(b[3:0]));
            chk("alu_op", 32'(alu_op), 32'(hdr_op));
        end
        $display("byte %02h accepted t=%0t", b, $time);
    endtask

    task automatic send_cmd(input logic [7:0] h, input logic [7:0] o);
        send_byte(h);
        send_byte(o);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
        chk("drain_left", 32'(sb.size()), 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("out_valid_empty", 32'(out_valid), 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("rst_alu", {alu_a, alu_b, 1'b0, alu_op}, 32'd0);
        chk("rst_sync_err", 32'(sync_err), 32'd0);
        rst_n = 1'b1;
        hdr_pending = 1'b0;
        exp_sync = 1'b0;
        sb.delete();
    endtask

    initial begin
        int p0;
        logic [7:0] b;
        repeat (2) @(posedge clk);
        do_reset();
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Single ADD with latency checks
        rdy_man = 1'b1;
        send_cmd(8'h80, 8'h35);
        @(negedge clk);
        chk("add_valid_e0", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("add_valid_e1", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("add_valid_e2", 32'(out_valid), 32'd1);
        chk("add_data", 32'(out_data), 32'h08);
        wait_drain();

        // Mixed ops back-to-back, 4-cycle spacing
        pop_cyc.delete();
        send_cmd(8'h81, 8'h35);
        send_cmd(8'h86, 8'hF3);
        send_cmd(8'h87, 8'h92);
        send_cmd(8'h85, 8'hC2);
        wait_drain();
        chk("mixed_count", 32'(pop_cyc.size()), 32'd4);
        for (int i = 1; i < pop_cyc.size(); i++)
            chk("mixed_spacing", 32'(pop_cyc[i] - pop_cyc[i-1]), 32'd4);

        // Framing error
        send_byte(8'h05);
        chk("sync_err_set", 32'(sync_err), 32'(exp_sync));
        send_cmd(8'h80, 8'h12);
        wait_drain();
        chk("sync_err_sticky", 32'(sync_err), 32'd1);

        // FIFO full, stall, then full-plus-pop
        @(posedge clk);
        #1;
        rdy_man = 1'b0;
        for (int i = 1; i <= 5; i++) send_cmd(8'h80, 8'(i));
        repeat (3) @(negedge clk);
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        chk("stall_out_valid", 32'(out_valid), 32'd1);
        chk("stall_head", 32'(out_data), 32'h01);
        p0 = n_pops;
        @(posedge clk);
        #1;
        rdy_man = 1'b1;
        @(posedge clk);
        #1;
        rdy_man = 1'b0;
        @(negedge clk);
        chk("fullpop_pops", 32'(n_pops - p0), 32'd1);
        chk("fullpop_hdr", 32'(in_ready), 32'd1);
        chk("fullpop_head", 32'(out_data), 32'h02);
        p0 = n_pops;
        rdy_man = 1'b1;
        wait_drain();
        chk("fullpop_count", 32'(n_pops - p0), 32'd4);

        // Reset mid-command
        send_byte(8'h80);
        do_reset();
        send_cmd(8'h80, 8'h11);
        wait_drain();
        chk("reset_sync_err", 32'(sync_err), 32'd0);

        // Randomized traffic with random output backpressure
        rdy_mode = 1'b1;
        for (int i = 0; i < 60; i++) begin
            b = 8'($urandom);
            if (!hdr_pending && $urandom_range(0, 4) != 0) b[7] = 1'b1;
            send_byte(b);
            if (!hdr_pending) chk("rand_sync_err", 32'(sync_err), 32'(exp_sync));
        end
        if (hdr_pending) send_byte(8'($urandom));
        @(posedge clk);
        #1;
        rdy_mode = 1'b0;
        rdy_man = 1'b1;
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_cmd_issuer.md
# alu_cmd_issuer

Command front-end for the `alu_4bit` block. It accepts two-byte ALU commands over a byte-wide valid/ready stream and drives `A`, `B` and `op` into the ALU. It then captures the ALU's registered 8-bit result and returns it through a small result FIFO on an output valid/ready stream. It is the initiator side of the ALU interface and sits between the pin-level byte bus and `alu_4bit`.

## Interface
- `DEPTH`, default 4: result FIFO entries, power of two, ≥2.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `in_data` in 8: command byte.
- `in_valid` in 1: `in_data` valid.
- `in_ready` out 1: byte accepted on an edge where `in_valid && in_ready`.
- `alu_a` out 4: operand A to the ALU; registered.
- `alu_b` out 4: operand B to the ALU; registered.
- `alu_op` out 3: opcode to the ALU; registered.
- `alu_result` in 8: ALU registered result, valid one edge after `alu_a`/`alu_b`/`alu_op` are stable.
- `out_data` out 8: FIFO head result.
- `out_valid` out 1: FIFO non-empty.
- `out_ready` in 1: pop on an edge where `out_valid && out_ready`.
- `sync_err` out 1: sticky framing-error flag.

## Operation
- **Command format**
  - Byte0 (header): bit7 must be 1; bits[2:0] = op; bits[6:3] ignored.
  - Byte1 (operands): {A[7:4], B[3:0]}.
- **FSM states:** HDR, OPND, EXEC, CAPT.
- **HDR:** `in_ready`=1.
  - Accepted byte with bit7=1: latch op, go to OPND.
  - Accepted byte with bit7=0: drop the byte, set `sync_err`, stay in HDR.
- **OPND:** `in_ready`=1.
  - On accept, load `alu_a`/`alu_b` from the byte and `alu_op` from the latched op, go to EXEC.
  - There is no timeout; the FSM waits indefinitely.
- **EXEC:** `in_ready`=0. The ALU samples the operands on this edge. Go to CAPT.
- **CAPT:** `in_ready`=0.
  - If the FIFO is not full, or is full with a pop on the same edge, push `alu_result` and go to HDR.
  - Otherwise stay in CAPT. `alu_*` are held, so `alu_result` stays stable.
- **Operand hold:** `alu_a`/`alu_b`/`alu_op` hold their last values outside OPND-accept.
- **FIFO**
  - Circular buffer with `DEPTH` entries, a `log2(DEPTH)+1`-bit count, and read/write pointers wrapping modulo `DEPTH`.
  - Push and pop on the same edge:
    - Non-empty: count is unchanged.
    - Empty: pop is ignored (`out_valid`=0) and the push lands.
  - `out_data` = entry at the read pointer; it is don't-care when empty.
- **Result width:** results are passed through unmodified, 8 bits. No sign or width handling is done here.
- **`sync_err`:** cleared only by reset.

## Timing
- **Reset (`rst_n`=0 at an edge)**
  - State → HDR, FIFO emptied, pointers and count → 0.
  - `alu_a`/`alu_b`/`alu_op` → 0, `sync_err` → 0.
  - While `rst_n` is low: `in_ready`=0, `out_valid`=0.
  - A partial command is discarded on reset; the first byte after reset is treated as a header.
- **Latency:** let E be the byte1 handshake edge.
  - `alu_*` are valid after E.
  - The ALU result is valid after E+1.
  - The FIFO push happens at E+2, so `out_valid` can rise in the cycle after E+2.
  - `in_ready` returns high after E+2.
- **Throughput:** 4 cycles per command with no backpressure.
- **Input side:** `in_ready` depends only on state (and `rst_n`). It never combinationally depends on `in_valid`.
- **Output side:** `out_valid` depends only on FIFO count. It never depends on `out_ready`.

## Test plan
- **ADD.** Reset, then send 0x80, 0x35.
  - `alu_a`=3, `alu_b`=5, `alu_op`=0 after E.
  - `out_data`=0x08 with `out_valid`=1 after E+2.
- **Mixed ops back-to-back** (`out_ready`=1): 0x81/0x35, 0x86/0xF3, 0x87/0x92, 0x85/0xC2.
  - Outputs in order: 0xFE, 0x78, 0x01, 0x03.
  - Spacing is 4 cycles per result.
- **Framing error.** Send 0x05, then 0x80, 0x12.
  - `sync_err`=1 from the edge after 0x05 accept onward.
  - Single result 0x03.
- **FIFO full.** Hold `out_ready`=0 and issue five ADD commands 0x80/0x01 … 0x80/0x05.
  - Four results are stored; the fifth command stalls in CAPT with `in_ready`=0.
  - Raise `out_ready`: drain yields 0x01, 0x02, 0x03, 0x04, 0x05 in order, with no loss.
- **Full plus simultaneous pop.** With the FIFO full and in CAPT, assert `out_ready` for one cycle.
  - Pop and push occur on the same edge; count stays at `DEPTH`.
  - FSM returns to HDR.
- **Reset mid-command.** Accept 0x80, then drive `rst_n`=0 for one cycle.
  - `out_valid`=0 and `alu_*`=0.
  - Following bytes 0x80, 0x11 produce a single 0x02.
